// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron input sequencer: default datapath widths,
// default pair count and the sequencer state encoding.
package neuron_pkg;

  localparam int NUM_INPUTS_DEF = 784;
  localparam int WEIGHT_W_DEF   = 19;
  localparam int PIXEL_W_DEF    = 10;
  localparam int ACC_W_DEF      = 26;
  localparam int MULT_LAT_DEF   = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_STREAM  = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_CAPTURE = 3'd4
  } seq_state_e;

  // Buffer address width; a single-entry buffer still gets one address bit.
  function automatic int addrWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/neuron_en_delay.sv
// Delays the multiply enable by DEPTH cycles to form the accumulate enable.
// Also flags when no enable will remain in flight after the current cycle,
// which lets the sequencer leave DRAIN exactly as the last accumulate lands.
module neuron_en_delay #(
  parameter int DEPTH = 1
) (
  input  logic Clk_i,
  input  logic GlobalReset_i,
  input  logic En_i,
  output logic En_o,
  output logic EmptyNext_o
);

  logic [DEPTH-1:0] shift_q;
  logic [DEPTH-1:0] shift_d;

  // Next shift-register contents: new enable enters at bit 0.
  always_comb begin
    shift_d    = '0;
    shift_d[0] = En_i;
    for (int i = 1; i < DEPTH; i++) begin
      shift_d[i] = shift_q[i-1];
    end
  end

  // Only the output stage may still be set when nothing follows it.
  always_comb begin
    EmptyNext_o = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (shift_q[i]) begin
        EmptyNext_o = 1'b0;
      end
    end
  end

  // Shift register with synchronous flush.
  always_ff @(posedge Clk_i) begin
    if (!GlobalReset_i) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign En_o = shift_q[DEPTH-1];

endmodule

// File: rtl/neuron_sequencer.sv
// Feeds one Neuron from the weight/pixel buffer and captures its result.
// Reads are issued in STREAM, data is registered one cycle after it returns,
// and the accumulate enable trails the multiply enable by MULT_LAT cycles.
module neuron_sequencer
  import neuron_pkg::*;
#(
  parameter int NUM_INPUTS = NUM_INPUTS_DEF,
  parameter int WEIGHT_W   = WEIGHT_W_DEF,
  parameter int PIXEL_W    = PIXEL_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int MULT_LAT   = MULT_LAT_DEF,
  parameter int ADDR_W     = addrWidth(NUM_INPUTS)
) (
  input  logic                Clk_i,
  input  logic                GlobalReset_i,
  input  logic                Start_i,
  input  logic                Stall_i,
  output logic                Rd_en_o,
  output logic [ADDR_W-1:0]   Addr_o,
  input  logic [WEIGHT_W-1:0] Weight_data_i,
  input  logic [PIXEL_W-1:0]  Pixel_data_i,
  output logic [WEIGHT_W-1:0] Weight_o,
  output logic [PIXEL_W-1:0]  Pixel_o,
  output logic                Mult_en_o,
  output logic                Add_en_o,
  output logic                Neuron_clr_o,
  input  logic [ACC_W-1:0]    Neuron_out_i,
  output logic [ACC_W-1:0]    Result_o,
  output logic                Result_valid_o,
  output logic                Busy_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_INPUTS - 1);

  seq_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   addrCnt_q, addrCnt_d;
  logic                readIssue;
  logic                dataPending_q;
  logic                multEn_q;
  logic [WEIGHT_W-1:0] weight_q;
  logic [PIXEL_W-1:0]  pixel_q;
  logic [ACC_W-1:0]    result_q;
  logic                resultValid_q;
  logic                addEn;
  logic                laneEmptyNext;

  // Sequencer next state, read strobe and address advance.
  always_comb begin
    state_d   = state_q;
    addrCnt_d = addrCnt_q;
    readIssue = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start_i) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        addrCnt_d = '0;
        state_d   = ST_STREAM;
      end
      ST_STREAM: begin
        if (!Stall_i) begin
          readIssue = 1'b1;
          if (addrCnt_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end else begin
            addrCnt_d = addrCnt_q + ADDR_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!dataPending_q && !multEn_q && laneEmptyNext) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and address counter registers.
  always_ff @(posedge Clk_i) begin
    if (!GlobalReset_i) begin
      state_q   <= ST_IDLE;
      addrCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addrCnt_q <= addrCnt_d;
    end
  end

  // Register returned buffer data and raise the multiply enable the cycle after.
  always_ff @(posedge Clk_i) begin
    if (!GlobalReset_i) begin
      dataPending_q <= 1'b0;
      multEn_q      <= 1'b0;
      weight_q      <= '0;
      pixel_q       <= '0;
    end else begin
      dataPending_q <= readIssue;
      multEn_q      <= dataPending_q;
      if (dataPending_q) begin
        weight_q <= Weight_data_i;
        pixel_q  <= Pixel_data_i;
      end
    end
  end

  // Capture the Neuron sum and pulse the valid flag alongside it.
  always_ff @(posedge Clk_i) begin
    if (!GlobalReset_i) begin
      result_q      <= '0;
      resultValid_q <= 1'b0;
    end else begin
      resultValid_q <= (state_q == ST_CAPTURE);
      if (state_q == ST_CAPTURE) begin
        result_q <= Neuron_out_i;
      end
    end
  end

  neuron_en_delay #(
    .DEPTH(MULT_LAT)
  ) u_en_delay (
    .Clk_i        (Clk_i),
    .GlobalReset_i(GlobalReset_i),
    .En_i         (multEn_q),
    .En_o         (addEn),
    .EmptyNext_o  (laneEmptyNext)
  );

  assign Rd_en_o        = readIssue;
  assign Addr_o         = addrCnt_q;
  assign Weight_o       = weight_q;
  assign Pixel_o        = pixel_q;
  assign Mult_en_o      = multEn_q;
  assign Add_en_o       = addEn;
  assign Neuron_clr_o   = (state_q == ST_CLEAR);
  assign Result_o       = result_q;
  assign Result_valid_o = resultValid_q;
  assign Busy_o         = (state_q != ST_IDLE);

endmodule
